// File: rtl/mem_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the memory-access pipeline stage:
//   - funct3 encodings for loads and stores
//   - stage FSM state enum {IDLE, BUSY, ERR}
//   - access-size enum and the funct3 -> size decode helper
// ---------------------------------------------------------------------------
package mem_access_stage_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Unknown codes fall back to a full-word access.
  function automatic acc_size_e decode_size(input logic [2:0] funct3,
                                            input logic       is_store);
    acc_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (funct3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_format.sv
// ---------------------------------------------------------------------------
// mem_load_format
// Combinational load formatter: picks the addressed byte/half lane out of the
// little-endian read word and sign- or zero-extends it according to funct3.
// Ports:
//   rdata  in  32  raw word returned by data memory
//   addr   in  2   byte offset within the word
//   funct3 in  3   load size/sign code
//   data   out 32  formatted load result
// ---------------------------------------------------------------------------
module mem_load_format
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    // Halves are aligned, so only addr[1] matters here.
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'd0, byte_lane};
      F3_LHU:  data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the pipeline: drives the data-memory handshake, stalls the
// pipe while waiting for dmem_ack, traps misaligned accesses, raises a sticky
// bus error after ACK_TIMEOUT unacknowledged cycles, and owns the M/WB register.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   m_* (EX/MEM buffer)         control, funct3, rd, address/ALU result,
//                               store data, LUI immediate, PC+4
//   dmem_req/we/addr/wdata/be   request side of the data-memory port
//   dmem_ack, dmem_rdata        response side of the data-memory port
//   mem_stall                   freeze EX/MEM and upstream
//   misaligned                  registered one-cycle pulse
//   bus_err                     sticky timeout flag
//   wb_RegWrite, wb_rd, wb_data M/WB register outputs
// ---------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_MemRead,
  input  logic        m_MemWrite,
  input  logic        m_MemToReg,
  input  logic        m_RegWrite,
  input  logic        m_JAL,
  input  logic        m_LUI,
  input  logic [2:0]  m_funct3,
  input  logic [4:0]  m_rd,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_mem_data,
  input  logic [31:0] m_sext_out,
  input  logic [31:0] m_pc_inc_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_e       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;
  logic             misaligned_reg;
  logic             wb_regwrite_reg;
  logic [4:0]       wb_rd_reg;
  logic [31:0]      wb_data_reg;

  logic             access;
  logic             is_store;
  acc_size_e        size;
  logic [1:0]       offset;
  logic             mis_now;
  logic [31:0]      load_data;
  logic [31:0]      wb_data_next;

  // Read wins when both controls are set.
  assign access   = m_MemRead | m_MemWrite;
  assign is_store = m_MemWrite & ~m_MemRead;
  assign size     = decode_size(m_funct3, is_store);
  assign offset   = m_alu_out[1:0];

  assign mis_now = access & (((size == SZ_WORD) && (offset != 2'd0)) ||
                             ((size == SZ_HALF) && offset[0]));

  // Request is combinational from IDLE so a same-cycle ack costs no stall.
  // Gating with rst_n drops an in-flight request the moment reset asserts.
  // Address/data/be come straight from EX/MEM, which the stall holds frozen.
  assign dmem_req = rst_n & (((state_reg == IDLE) & access & ~mis_now) |
                             (state_reg == BUSY));
  assign dmem_we   = dmem_req & is_store;
  assign dmem_addr = {m_alu_out[31:2], 2'b00};
  assign mem_stall = dmem_req & ~dmem_ack;

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = m_mem_data;
    if (is_store) begin
      case (size)
        SZ_BYTE: begin
          dmem_be    = 4'b0001 << offset;
          dmem_wdata = {4{m_mem_data[7:0]}};
        end
        SZ_HALF: begin
          dmem_be    = 4'b0011 << offset;
          dmem_wdata = {2{m_mem_data[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = m_mem_data;
        end
      endcase
    end
  end

  mem_load_format u_load_format (
    .rdata  (dmem_rdata),
    .addr   (offset),
    .funct3 (m_funct3),
    .data   (load_data)
  );

  always_comb begin
    if (m_JAL)           wb_data_next = m_pc_inc_out;
    else if (m_LUI)      wb_data_next = m_sext_out;
    else if (m_MemToReg) wb_data_next = load_data;
    else                 wb_data_next = m_alu_out;
  end

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      misaligned_reg  <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_rd_reg       <= 5'd0;
      wb_data_reg     <= 32'd0;
    end else begin
      misaligned_reg <= (state_reg == IDLE) && mis_now;

      case (state_reg)
        IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state_reg <= BUSY;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            state_reg <= IDLE;
          end else begin
            // The IDLE request cycle counts toward the timeout, so ERR is
            // entered after exactly ACK_TIMEOUT stalled cycles in total.
            cnt_reg <= cnt_inc;
            if (cnt_inc == CNT_LAST) state_reg <= ERR;
          end
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Stall keeps the previous result but kills its write enable.
      if (mem_stall) begin
        wb_regwrite_reg <= 1'b0;
      end else begin
        wb_regwrite_reg <= m_RegWrite && !mis_now && (state_reg != ERR);
        wb_rd_reg       <= m_rd;
        wb_data_reg     <= wb_data_next;
      end
    end
  end

  assign misaligned  = misaligned_reg;
  assign bus_err     = (state_reg == ERR);
  assign wb_RegWrite = wb_regwrite_reg;
  assign wb_rd       = wb_rd_reg;
  assign wb_data     = wb_data_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench for mem_access_stage (ACK_TIMEOUT = 4): a table of
// directed vectors, randomized instructions against a behavioural model,
// and hand-written stall / timeout / reset sequences.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_MemRead, m_MemWrite, m_MemToReg, m_RegWrite, m_JAL, m_LUI;
  logic [2:0]  m_funct3;
  logic [4:0]  m_rd;
  logic [31:0] m_alu_out, m_mem_data, m_sext_out, m_pc_inc_out;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall, misaligned, bus_err, wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite), .m_MemToReg(m_MemToReg),
    .m_RegWrite(m_RegWrite), .m_JAL(m_JAL), .m_LUI(m_LUI),
    .m_funct3(m_funct3), .m_rd(m_rd), .m_alu_out(m_alu_out),
    .m_mem_data(m_mem_data), .m_sext_out(m_sext_out), .m_pc_inc_out(m_pc_inc_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .misaligned(misaligned),
    .bus_err(bus_err), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    logic        rd_en, wr_en, m2r, rw, jal, lui;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr, data, sext, pcinc;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [31:0] rdata;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wbwe;
    logic [31:0] wbdata;
    logic        mis;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic r, w, m2r, rw, jal, lui,
                                input logic [2:0] f3, input logic [4:0] rd,
                                input logic [31:0] addr, data, sext, pcinc);
    instr_t i;
    i.rd_en = r; i.wr_en = w; i.m2r = m2r; i.rw = rw; i.jal = jal; i.lui = lui;
    i.f3 = f3; i.rd = rd; i.addr = addr; i.data = data; i.sext = sext; i.pcinc = pcinc;
    return i;
  endfunction

  function automatic vec_t mkv(input instr_t ins, input logic [31:0] rdata,
                               input logic req, we, input logic [3:0] be,
                               input logic [31:0] wdata, input logic wbwe,
                               input logic [31:0] wbdata, input logic mis);
    vec_t v;
    v.ins = ins; v.rdata = rdata; v.req = req; v.we = we; v.be = be;
    v.wdata = wdata; v.wbwe = wbwe; v.wbdata = wbdata; v.mis = mis;
    return v;
  endfunction

  task automatic drive(input instr_t i);
    m_MemRead = i.rd_en; m_MemWrite = i.wr_en; m_MemToReg = i.m2r;
    m_RegWrite = i.rw; m_JAL = i.jal; m_LUI = i.lui; m_funct3 = i.f3;
    m_rd = i.rd; m_alu_out = i.addr; m_mem_data = i.data;
    m_sext_out = i.sext; m_pc_inc_out = i.pcinc;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int size_of(input instr_t i);
    if (i.wr_en && !i.rd_en)
      return (i.f3 == 3'd0) ? 1 : (i.f3 == 3'd1) ? 2 : 4;
    return (i.f3 == 3'd0 || i.f3 == 3'd4) ? 1 : (i.f3 == 3'd1 || i.f3 == 3'd5) ? 2 : 4;
  endfunction

  function automatic logic is_mis(input instr_t i);
    return (i.rd_en || i.wr_en) && ((i.addr % size_of(i)) != 0);
  endfunction

  function automatic logic [3:0] model_be(input instr_t i);
    int m;
    if (i.rd_en) return 4'hF;
    m = ((1 << size_of(i)) - 1) << (i.addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input instr_t i);
    logic [31:0] b, h;
    b = {24'd0, i.data[7:0]};
    h = {16'd0, i.data[15:0]};
    case (size_of(i))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return i.data;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input instr_t i, input logic [31:0] rdata);
    longint unsigned v, lim;
    int off, sz;
    off = int'(i.addr % 4);
    sz  = size_of(i);
    v   = 64'(rdata) >> (8 * off);
    lim = 64'd1 << (8 * sz);
    v   = v % lim;
    if (i.f3 < 3'd4 && sz < 4 && v >= lim / 2)
      v = v + (64'd1 << 32) - lim;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_wb(input instr_t i, input logic [31:0] rdata);
    if (i.jal) return i.pcinc;
    if (i.lui) return i.sext;
    if (i.m2r) return model_load(i, rdata);
    return i.addr;
  endfunction

  // Watchdog: the run must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  instr_t idle_i, alu_i, ld_i;
  vec_t   tbl[14];

  initial begin
    idle_i = mk(0,0,0,0,0,0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    drive(idle_i);
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
    rst_n = 1'b0;

    // ------------------------------------------------------------ reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", {31'd0, dmem_req}, 32'd0);
    chk("rst.wb_we", {31'd0, wb_RegWrite}, 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst.bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst.mis", {31'd0, misaligned}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ------------------------------------------------------------ table
    //            r w m2r rw jal lui f3     rd    addr          data          sext          pcinc
    tbl[0]  = mkv(mk(1,0,1,1,0,0, 3'b000, 5'd5,  32'h0000_1003, 32'd0,        32'd0,        32'd0),
                  32'h80FF_1234, 1,0, 4'hF, 32'd0,         1, 32'hFFFF_FF80, 0);
    tbl[1]  = mkv(mk(1,0,1,1,0,0, 3'b010, 5'd6,  32'h0000_3001, 32'd0,        32'd0,        32'd0),
                  32'h0,         0,0, 4'hF, 32'd0,         0, 32'd0,         1);
    tbl[2]  = mkv(mk(0,0,0,1,1,0, 3'b000, 5'd1,  32'h0000_0040, 32'd0,        32'd0,        32'h104),
                  32'h0,         0,0, 4'hF, 32'd0,         1, 32'h0000_0104, 0);
    tbl[3]  = mkv(mk(0,0,0,1,0,1, 3'b000, 5'd2,  32'h0000_0099, 32'd0,        32'h1234_5000, 32'd0),
                  32'h0,         0,0, 4'hF, 32'd0,         1, 32'h1234_5000, 0);
    tbl[4]  = mkv(mk(1,0,1,1,0,0, 3'b101, 5'd8,  32'h0000_4002, 32'd0,        32'd0,        32'd0),
                  32'h89AB_0123, 1,0, 4'hF, 32'd0,         1, 32'h0000_89AB, 0);
    tbl[5]  = mkv(mk(1,0,1,1,0,0, 3'b001, 5'd9,  32'h0000_4000, 32'd0,        32'd0,        32'd0),
                  32'h0001_8000, 1,0, 4'hF, 32'd0,         1, 32'hFFFF_8000, 0);
    tbl[6]  = mkv(mk(1,0,1,1,0,0, 3'b100, 5'd10, 32'h0000_5001, 32'd0,        32'd0,        32'd0),
                  32'h0000_C300, 1,0, 4'hF, 32'd0,         1, 32'h0000_00C3, 0);
    tbl[7]  = mkv(mk(0,1,0,0,0,0, 3'b000, 5'd0,  32'h0000_6002, 32'h1234_5678, 32'd0,      32'd0),
                  32'h0,         1,1, 4'h4, 32'h7878_7878, 0, 32'd0,         0);
    tbl[8]  = mkv(mk(0,1,0,0,0,0, 3'b010, 5'd0,  32'h0000_7000, 32'hDEAD_BEEF, 32'd0,      32'd0),
                  32'h0,         1,1, 4'hF, 32'hDEAD_BEEF, 0, 32'd0,         0);
    tbl[9]  = mkv(mk(0,0,0,1,0,0, 3'b000, 5'd11, 32'hCAFE_0001, 32'd0,        32'd0,        32'd0),
                  32'h0,         0,0, 4'hF, 32'd0,         1, 32'hCAFE_0001, 0);
    tbl[10] = mkv(mk(0,1,0,0,0,0, 3'b001, 5'd0,  32'h0000_8001, 32'h0000_5555, 32'd0,      32'd0),
                  32'h0,         0,0, 4'hF, 32'd0,         0, 32'd0,         1);
    tbl[11] = mkv(mk(1,0,1,1,0,0, 3'b010, 5'd12, 32'h0000_9004, 32'd0,        32'd0,        32'd0),
                  32'h1122_3344, 1,0, 4'hF, 32'd0,         1, 32'h1122_3344, 0);
    tbl[12] = mkv(mk(1,1,1,1,0,0, 3'b010, 5'd13, 32'h0000_A000, 32'h7777_7777, 32'd0,      32'd0),
                  32'h0BAD_F00D, 1,0, 4'hF, 32'd0,         1, 32'h0BAD_F00D, 0);
    tbl[13] = mkv(mk(0,1,0,1,0,0, 3'b001, 5'd14, 32'h0000_B00A, 32'h1111_ABCD, 32'd0,      32'd0),
                  32'h0,         1,1, 4'hC, 32'hABCD_ABCD, 1, 32'h0000_B00A, 0);

    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      drive(tbl[k].ins);
      dmem_rdata = tbl[k].rdata;
      dmem_ack   = tbl[k].req;
      #1;
      chk($sformatf("vec%0d.req", k), {31'd0, dmem_req}, {31'd0, tbl[k].req});
      chk($sformatf("vec%0d.stall", k), {31'd0, mem_stall}, 32'd0);
      if (tbl[k].req) begin
        chk($sformatf("vec%0d.we", k), {31'd0, dmem_we}, {31'd0, tbl[k].we});
        chk($sformatf("vec%0d.be", k), {28'd0, dmem_be}, {28'd0, tbl[k].be});
        chk($sformatf("vec%0d.addr", k), dmem_addr, tbl[k].ins.addr & 32'hFFFF_FFFC);
        if (tbl[k].we) chk($sformatf("vec%0d.wdata", k), dmem_wdata, tbl[k].wdata);
      end
      @(posedge clk); #1;
      $display("vec %0d: addr=0x%08h wb_we=%0b wb_data=0x%08h mis=%0b",
               k, tbl[k].ins.addr, wb_RegWrite, wb_data, misaligned);
      chk($sformatf("vec%0d.wb_we", k), {31'd0, wb_RegWrite}, {31'd0, tbl[k].wbwe});
      chk($sformatf("vec%0d.mis", k), {31'd0, misaligned}, {31'd0, tbl[k].mis});
      if (tbl[k].wbwe) begin
        chk($sformatf("vec%0d.wb_data", k), wb_data, tbl[k].wbdata);
        chk($sformatf("vec%0d.wb_rd", k), {27'd0, wb_rd}, {27'd0, tbl[k].ins.rd});
      end
    end

    // ------------------------------------------------------------ random
    for (int n = 0; n < 150; n++) begin
      instr_t ri;
      int kind, dly, sz;
      logic [31:0] rdata, exp_wb;
      logic exp_req, exp_mis, exp_wbwe;
      ri = idle_i;
      kind = int'($urandom_range(0, 9));
      ri.rd = 5'($urandom_range(0, 31));
      ri.addr = $urandom; ri.data = $urandom; ri.sext = $urandom; ri.pcinc = $urandom;
      if (kind <= 3) begin
        ri.rd_en = 1'b1; ri.m2r = 1'b1; ri.rw = 1'b1;
        case ($urandom_range(0, 4))
          0: ri.f3 = 3'd0; 1: ri.f3 = 3'd1; 2: ri.f3 = 3'd2; 3: ri.f3 = 3'd4; default: ri.f3 = 3'd5;
        endcase
      end else if (kind <= 6) begin
        ri.wr_en = 1'b1; ri.rw = 1'($urandom_range(0, 1));
        ri.f3 = 3'($urandom_range(0, 2));
      end else begin
        ri.rw = 1'b1; ri.jal = (kind == 8); ri.lui = (kind == 9);
      end
      sz = size_of(ri);
      if ($urandom_range(0, 3) != 0) ri.addr = ri.addr - (ri.addr % sz);
      rdata    = $urandom;
      dly      = int'($urandom_range(0, TO - 1));
      exp_mis  = is_mis(ri);
      exp_req  = (ri.rd_en || ri.wr_en) && !exp_mis;
      exp_wbwe = ri.rw && !exp_mis;
      exp_wb   = model_wb(ri, rdata);

      @(negedge clk);
      drive(ri);
      if (!exp_req) begin
        dmem_ack = 1'b0; dmem_rdata = rdata;
        #1;
        chk($sformatf("rnd%0d.req", n), {31'd0, dmem_req}, 32'd0);
        chk($sformatf("rnd%0d.stall", n), {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
      end else begin
        for (int c = 0; c <= dly; c++) begin
          if (c > 0) @(negedge clk);
          dmem_ack   = (c == dly);
          dmem_rdata = (c == dly) ? rdata : $urandom;
          #1;
          chk($sformatf("rnd%0d.req", n), {31'd0, dmem_req}, 32'd1);
          chk($sformatf("rnd%0d.stall", n), {31'd0, mem_stall}, {31'd0, c != dly});
          chk($sformatf("rnd%0d.be", n), {28'd0, dmem_be}, {28'd0, model_be(ri)});
          chk($sformatf("rnd%0d.addr", n), dmem_addr, ri.addr - (ri.addr % 4));
          chk($sformatf("rnd%0d.we", n), {31'd0, dmem_we}, {31'd0, ri.wr_en && !ri.rd_en});
          if (ri.wr_en && !ri.rd_en)
            chk($sformatf("rnd%0d.wdata", n), dmem_wdata, model_wdata(ri));
          @(posedge clk); #1;
          if (c != dly) chk($sformatf("rnd%0d.bubble", n), {31'd0, wb_RegWrite}, 32'd0);
        end
        dmem_ack = 1'b0;
      end
      $display("rnd %0d: kind=%0d f3=%0d addr=0x%08h wb_we=%0b wb_data=0x%08h",
               n, kind, ri.f3, ri.addr, wb_RegWrite, wb_data);
      chk($sformatf("rnd%0d.wb_we", n), {31'd0, wb_RegWrite}, {31'd0, exp_wbwe});
      chk($sformatf("rnd%0d.mis", n), {31'd0, misaligned}, {31'd0, exp_mis});
      if (exp_wbwe) begin
        chk($sformatf("rnd%0d.wb_data", n), wb_data, exp_wb);
        chk($sformatf("rnd%0d.wb_rd", n), {27'd0, wb_rd}, {27'd0, ri.rd});
      end
    end

    // ------------------------------------------------------------ SH with 3 stall cycles
    alu_i = mk(0,0,0,1,0,0, 3'd0, 5'd7, 32'h55AA_55AA, 32'd0, 32'd0, 32'd0);
    @(negedge clk); drive(alu_i); dmem_ack = 1'b0;
    @(posedge clk); #1;
    chk("sh.pre_wb_data", wb_data, 32'h55AA_55AA);
    @(negedge clk);
    drive(mk(0,1,0,0,0,0, 3'b001, 5'd3, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 32'd0));
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      dmem_ack = (c == 3);
      #1;
      chk($sformatf("sh.c%0d.req", c), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("sh.c%0d.stall", c), {31'd0, mem_stall}, {31'd0, c != 3});
      chk($sformatf("sh.c%0d.be", c), {28'd0, dmem_be}, 32'hC);
      chk($sformatf("sh.c%0d.wdata", c), dmem_wdata, 32'hBEEF_BEEF);
      chk($sformatf("sh.c%0d.addr", c), dmem_addr, 32'h0000_2000);
      @(posedge clk); #1;
      $display("sh cycle %0d: stall_next=%0b wb_we=%0b wb_data=0x%08h", c, mem_stall, wb_RegWrite, wb_data);
      chk($sformatf("sh.c%0d.wb_we", c), {31'd0, wb_RegWrite}, 32'd0);
      if (c != 3) chk($sformatf("sh.c%0d.wb_hold", c), wb_data, 32'h55AA_55AA);
    end

    // ------------------------------------------------------------ timeout -> ERR
    @(negedge clk);
    dmem_ack = 1'b0;
    drive(mk(1,0,1,1,0,0, 3'b010, 5'd4, 32'h0000_B000, 32'd0, 32'd0, 32'd0));
    for (int c = 0; c < TO; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("to.c%0d.stall", c), {31'd0, mem_stall}, 32'd1);
      chk($sformatf("to.c%0d.bus_err", c), {31'd0, bus_err}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("to.c%0d.wb_we", c), {31'd0, wb_RegWrite}, 32'd0);
    end
    $display("timeout: bus_err=%0b stall=%0b req=%0b", bus_err, mem_stall, dmem_req);
    chk("to.bus_err", {31'd0, bus_err}, 32'd1);
    chk("to.stall", {31'd0, mem_stall}, 32'd0);
    chk("to.req", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    drive(mk(0,0,0,1,1,0, 3'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'h0000_0200));
    #1;
    chk("err.req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    chk("err.wb_we", {31'd0, wb_RegWrite}, 32'd0);
    chk("err.sticky", {31'd0, bus_err}, 32'd1);

    // ------------------------------------------------------------ reset clears ERR
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("err_rst.bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(alu_i);
    @(posedge clk); #1;
    chk("post_rst.wb_data", wb_data, 32'h55AA_55AA);

    // ------------------------------------------------------------ reset during BUSY
    ld_i = mk(1,0,1,1,0,0, 3'b010, 5'd15, 32'h0000_C000, 32'd0, 32'd0, 32'd0);
    @(negedge clk); drive(ld_i); dmem_ack = 1'b0;
    @(posedge clk);   // now BUSY
    @(posedge clk); #3;
    chk("busy.req", {31'd0, dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    $display("reset in BUSY: req=%0b wb_we=%0b wb_rd=%0d wb_data=0x%08h", dmem_req, wb_RegWrite, wb_rd, wb_data);
    chk("mid_rst.req", {31'd0, dmem_req}, 32'd0);
    chk("mid_rst.stall", {31'd0, mem_stall}, 32'd0);
    chk("mid_rst.wb_we", {31'd0, wb_RegWrite}, 32'd0);
    chk("mid_rst.wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("mid_rst.wb_data", wb_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drive(alu_i);
    #1;
    // A non-memory instruction raising no request shows the FSM is back in IDLE.
    chk("rel.req", {31'd0, dmem_req}, 32'd0);
    chk("rel.bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    drive(ld_i); dmem_ack = 1'b1; dmem_rdata = 32'h0A0B_0C0D;
    #1;
    chk("rel.ld_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    chk("rel.ld_wb_we", {31'd0, wb_RegWrite}, 32'd1);
    chk("rel.ld_wb_data", wb_data, 32'h0A0B_0C0D);
    @(negedge clk); dmem_ack = 1'b0; drive(idle_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
